// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART peripheral: register addresses,
// status/control bit positions, the serial FSM state type and the minimum
// baud divisor, plus a helper that clamps a programmed divisor.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [3:0] UART_DATA = 4'd0;
    localparam logic [3:0] UART_STAT = 4'd1;
    localparam logic [3:0] UART_CTRL = 4'd2;
    localparam logic [3:0] UART_DIV  = 4'd4;

    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_TX_FULL    = 2;
    localparam int STAT_TX_IDLE    = 3;
    localparam int STAT_RX_OVERRUN = 4;
    localparam int STAT_FRAME_ERR  = 5;
    localparam int STAT_TX_DROP    = 6;

    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TX_IE  = 1;
    localparam int CTRL_ERR_IE = 2;
    localparam int CTRL_LOOP   = 3;

    localparam logic [15:0] MIN_DIV = 16'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uartState_t;

    // Very small divisors would leave no room to find the middle of a bit,
    // so anything below MIN_DIV is treated as MIN_DIV.
    function automatic logic [15:0] effectiveDiv(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO used for both the TX and RX byte queues.
//   clk      : system clock
//   reset    : asynchronous active-low reset, empties the FIFO
//   i_push   : write i_data (ignored when full unless a pop happens too)
//   i_data   : data to write
//   i_pop    : remove the head entry (ignored when empty)
//   o_full   : FIFO holds DEPTH entries
//   o_empty  : FIFO holds no entries
//   o_head   : oldest entry, valid when not empty
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_doPop;
    logic w_doPush;

    // The extra pointer MSB distinguishes full from empty when the index
    // bits match. A push into a full FIFO is still accepted when the same
    // cycle pops, since a slot frees up on that edge.
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);
    assign o_head   = r_mem[r_rdPtr[AW-1:0]];

    // Pointers wrap naturally through their full width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart
// Byte-wide 8N1 UART on the 16-bit I/O bus with TX/RX FIFOs, a programmable
// baud divisor (bit period = max(divisor,3)+1 clocks) and a registered level
// interrupt.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   io_write   : register write strobe
//   io_read    : register read strobe (pops RX FIFO at address 0)
//   io_addr    : register select (0 data, 1 status, 2 control, 4 divisor)
//   io_wdata   : write data
//   io_rdata   : combinational read data
//   uart_intr  : registered level interrupt
//   rx         : serial input, asynchronous to clk
//   tx         : registered serial output
// Build option: define UART_LOOPBACK_EN to implement control bit 3, which
// routes the internal TX stream into the RX synchroniser and parks tx high.
// ---------------------------------------------------------------------------
module uart
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [3:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic        uart_intr,
    input  logic        rx,
    output logic        tx
);

    logic [2:0]  r_ctrl;
    logic [15:0] r_div;
    logic        r_rxOverrun;
    logic        r_frameErr;
    logic        r_txDrop;
    logic        r_intr;

    uartState_t  r_txState;
    logic [15:0] r_txCnt;
    logic [2:0]  r_txIdx;
    logic [7:0]  r_txShift;
    logic        r_tx;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxPrev;
    uartState_t  r_rxState;
    logic [15:0] r_rxCnt;
    logic [2:0]  r_rxIdx;
    logic [7:0]  r_rxShift;

    logic [15:0] w_effDiv;
    logic        w_dataWr;
    logic        w_statWr;
    logic        w_ctrlWr;
    logic        w_divWr;
    logic        w_rxRd;
    logic        w_txPop;
    logic        w_txFull;
    logic        w_txEmpty;
    logic [7:0]  w_txHead;
    logic        w_txLine;
    logic        w_txIdle;
    logic        w_rxIn;
    logic        w_rxFall;
    logic        w_rxStopTick;
    logic        w_rxPush;
    logic        w_rxFull;
    logic        w_rxEmpty;
    logic [7:0]  w_rxHead;
    logic        w_overrunSet;
    logic        w_frameErrSet;
    logic        w_txDropSet;
    logic        w_loop;
    logic [6:0]  w_status;

    assign w_effDiv = effectiveDiv(r_div);

    assign w_dataWr = io_write && (io_addr == UART_DATA);
    assign w_statWr = io_write && (io_addr == UART_STAT);
    assign w_ctrlWr = io_write && (io_addr == UART_CTRL);
    assign w_divWr  = io_write && (io_addr == UART_DIV);
    assign w_rxRd   = io_read  && (io_addr == UART_DATA);

`ifdef UART_LOOPBACK_EN
    logic r_loop;
    logic r_txSer;

    // Loop control bit; only exists in the loopback build.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loop <= 1'b0;
        end else if (w_ctrlWr) begin
            r_loop <= io_wdata[CTRL_LOOP];
        end
    end

    // Registered copy of the TX stream that feeds the synchroniser in
    // loop mode, so loopback timing matches an external wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txSer <= 1'b1;
        end else begin
            r_txSer <= w_txLine;
        end
    end

    assign w_loop = r_loop;
    assign w_rxIn = r_loop ? r_txSer : rx;

    // In loop mode the pin idles high while the stream goes inward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= r_loop ? 1'b1 : w_txLine;
        end
    end
`else
    assign w_loop = 1'b0;
    assign w_rxIn = rx;

    // The pin is a register so it never glitches on FSM decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_txLine;
        end
    end
`endif

    assign tx = r_tx;

    // Control and divisor registers. The divisor is only sampled when a bit
    // counter reloads, so a new value starts at the next bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= 3'b000;
            r_div  <= DIV_RESET;
        end else begin
            if (w_ctrlWr) r_ctrl <= io_wdata[2:0];
            if (w_divWr)  r_div  <= io_wdata;
        end
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_dataWr),
        .i_data  (io_wdata[7:0]),
        .i_pop   (w_txPop),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty),
        .o_head  (w_txHead)
    );

    // A new byte is fetched either from idle or straight out of the stop
    // bit, which is what makes queued frames run back to back.
    assign w_txPop = ~w_txEmpty &&
                     ((r_txState == IDLE) ||
                      ((r_txState == STOP) && (r_txCnt == 16'd0)));
    assign w_txDropSet = w_dataWr && w_txFull && !w_txPop;
    assign w_txIdle    = w_txEmpty && (r_txState == IDLE);

    always_comb begin
        w_txLine = 1'b1;
        case (r_txState)
            START:   w_txLine = 1'b0;
            DATA:    w_txLine = r_txShift[r_txIdx];
            default: w_txLine = 1'b1;
        endcase
    end

    // Transmit sequencer: each state holds for effDiv+1 clocks, counted
    // down to zero, and data goes out LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txState <= IDLE;
            r_txCnt   <= 16'd0;
            r_txIdx   <= 3'd0;
            r_txShift <= 8'h00;
        end else begin
            case (r_txState)
                IDLE: begin
                    if (w_txPop) begin
                        r_txState <= START;
                        r_txShift <= w_txHead;
                        r_txCnt   <= w_effDiv;
                    end
                end
                START: begin
                    if (r_txCnt == 16'd0) begin
                        r_txState <= DATA;
                        r_txIdx   <= 3'd0;
                        r_txCnt   <= w_effDiv;
                    end else begin
                        r_txCnt <= r_txCnt - 16'd1;
                    end
                end
                DATA: begin
                    if (r_txCnt == 16'd0) begin
                        r_txCnt <= w_effDiv;
                        if (r_txIdx == 3'd7) begin
                            r_txState <= STOP;
                        end else begin
                            r_txIdx <= r_txIdx + 3'd1;
                        end
                    end else begin
                        r_txCnt <= r_txCnt - 16'd1;
                    end
                end
                STOP: begin
                    if (r_txCnt == 16'd0) begin
                        if (w_txPop) begin
                            r_txState <= START;
                            r_txShift <= w_txHead;
                            r_txCnt   <= w_effDiv;
                        end else begin
                            r_txState <= IDLE;
                        end
                    end else begin
                        r_txCnt <= r_txCnt - 16'd1;
                    end
                end
                default: r_txState <= IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detect.
    // Reset to the idle line level so no false start is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= w_rxIn;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    assign w_rxFall      = r_rxPrev & ~r_sync2;
    assign w_rxStopTick  = (r_rxState == STOP) && (r_rxCnt == 16'd0);
    assign w_rxPush      = w_rxStopTick & r_sync2;
    assign w_frameErrSet = w_rxStopTick & ~r_sync2;
    assign w_overrunSet  = w_rxPush & w_rxFull & ~w_rxRd;

    // Receive sequencer: a half-period delay after the falling edge lands
    // the sampling point mid-bit, after which every full period hits the
    // middle of the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxState <= IDLE;
            r_rxCnt   <= 16'd0;
            r_rxIdx   <= 3'd0;
            r_rxShift <= 8'h00;
        end else begin
            case (r_rxState)
                IDLE: begin
                    if (w_rxFall) begin
                        r_rxState <= START;
                        r_rxCnt   <= w_effDiv >> 1;
                    end
                end
                START: begin
                    if (r_rxCnt == 16'd0) begin
                        if (r_sync2) begin
                            r_rxState <= IDLE;
                        end else begin
                            r_rxState <= DATA;
                            r_rxIdx   <= 3'd0;
                            r_rxCnt   <= w_effDiv;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt - 16'd1;
                    end
                end
                DATA: begin
                    if (r_rxCnt == 16'd0) begin
                        r_rxShift <= {r_sync2, r_rxShift[7:1]};
                        r_rxCnt   <= w_effDiv;
                        if (r_rxIdx == 3'd7) begin
                            r_rxState <= STOP;
                        end else begin
                            r_rxIdx <= r_rxIdx + 3'd1;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt - 16'd1;
                    end
                end
                STOP: begin
                    if (r_rxCnt == 16'd0) begin
                        r_rxState <= IDLE;
                    end else begin
                        r_rxCnt <= r_rxCnt - 16'd1;
                    end
                end
                default: r_rxState <= IDLE;
            endcase
        end
    end

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rxFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rxPush),
        .i_data  (r_rxShift),
        .i_pop   (w_rxRd),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty),
        .o_head  (w_rxHead)
    );

    // Sticky error flags: a new event in the same cycle as a clear wins,
    // so no error is ever silently lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxOverrun <= 1'b0;
            r_frameErr  <= 1'b0;
            r_txDrop    <= 1'b0;
        end else begin
            if (w_overrunSet) begin
                r_rxOverrun <= 1'b1;
            end else if (w_statWr && io_wdata[STAT_RX_OVERRUN]) begin
                r_rxOverrun <= 1'b0;
            end
            if (w_frameErrSet) begin
                r_frameErr <= 1'b1;
            end else if (w_statWr && io_wdata[STAT_FRAME_ERR]) begin
                r_frameErr <= 1'b0;
            end
            if (w_txDropSet) begin
                r_txDrop <= 1'b1;
            end else if (w_statWr && io_wdata[STAT_TX_DROP]) begin
                r_txDrop <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status = 7'd0;
        w_status[STAT_RX_VALID]   = ~w_rxEmpty;
        w_status[STAT_RX_FULL]    = w_rxFull;
        w_status[STAT_TX_FULL]    = w_txFull;
        w_status[STAT_TX_IDLE]    = w_txIdle;
        w_status[STAT_RX_OVERRUN] = r_rxOverrun;
        w_status[STAT_FRAME_ERR]  = r_frameErr;
        w_status[STAT_TX_DROP]    = r_txDrop;
    end

    // Interrupt is registered, so it trails the status change by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= (r_ctrl[CTRL_RX_IE]  & ~w_rxEmpty) |
                      (r_ctrl[CTRL_TX_IE]  & w_txEmpty)  |
                      (r_ctrl[CTRL_ERR_IE] & (r_rxOverrun | r_frameErr | r_txDrop));
        end
    end

    assign uart_intr = r_intr;

    always_comb begin
        io_rdata = 16'h0000;
        case (io_addr)
            UART_DATA: io_rdata = w_rxEmpty ? 16'h0000 : {8'h00, w_rxHead};
            UART_STAT: io_rdata = {9'h000, w_status};
            UART_CTRL: io_rdata = {12'h000, w_loop, r_ctrl};
            UART_DIV:  io_rdata = r_div;
            default:   io_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart
// Self-checking bench for the uart block. Register reads push their expected
// value into readQ and TX writes push the expected byte into txQ; two monitor
// processes pop and compare when the DUT presents a read or a serial frame.
// Loopback checks are built only when UART_LOOPBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart;

    logic        clk;
    logic        reset;
    logic        io_write;
    logic        io_read;
    logic [3:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        uart_intr;
    logic        rx;
    logic        tx;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } rdExp_t;

    rdExp_t     readQ[$];
    logic [7:0] txQ[$];

    int checks = 0;
    int errors = 0;
    int bitPeriod = 4;
    bit monEnable = 1'b1;

    uart #(.FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .uart_intr (uart_intr),
        .rx        (rx),
        .tx        (tx)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stop a hung run with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every task starts and ends 1ns after a rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [15:0] data);
        io_write = 1'b1;
        io_addr  = addr;
        io_wdata = data;
        waitCycles(1);
        io_write = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, input logic [15:0] expData);
        rdExp_t e;
        e.addr = addr;
        e.data = expData;
        readQ.push_back(e);
        io_read = 1'b1;
        io_addr = addr;
        waitCycles(1);
        io_read = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        waitCycles(bitPeriod);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitCycles(bitPeriod);
        end
        rx = stopBit;
        waitCycles(bitPeriod);
        rx = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Read monitor: every read strobe is matched against the oldest
    // expected read value.
    initial begin
        forever begin
            @(negedge clk);
            if (io_read === 1'b1) begin
                checks++;
                if (readQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL read_unexpected: addr %0d data %h", io_addr, io_rdata);
                end else begin
                    rdExp_t e;
                    e = readQ.pop_front();
                    if (io_rdata !== e.data) begin
                        errors++;
                        $display("[TB] FAIL read_addr%0d: got %h expected %h",
                                 e.addr, io_rdata, e.data);
                    end
                end
            end
        end
    end

    // TX monitor: decodes frames from the pin at mid-bit points and
    // compares the whole 10-bit frame with the expected byte.
    initial begin
        logic [9:0] got;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b1) begin
                repeat (bitPeriod / 2) @(negedge clk);
                got[0] = tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (bitPeriod) @(negedge clk);
                    got[i] = tx;
                end
                if (monEnable) begin
                    checks++;
                    if (txQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL tx_unexpected: frame %b", got);
                    end else begin
                        exp = txQ.pop_front();
                        if (got !== {1'b1, exp, 1'b0}) begin
                            errors++;
                            $display("[TB] FAIL tx_frame: got %b expected %b",
                                     got, {1'b1, exp, 1'b0});
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [2:0] lat;
        logic [9:0] frame;
        logic       expLvl;
        int         bad;
        int         firstBad;
        bit         txHigh;

        reset    = 1'b0;
        io_write = 1'b0;
        io_read  = 1'b0;
        io_addr  = 4'd0;
        io_wdata = 16'h0000;
        rx       = 1'b1;

        // Reset state.
        waitCycles(3);
        checkOutput("reset_tx", {15'd0, tx}, 16'h0001);
        checkOutput("reset_intr", {15'd0, uart_intr}, 16'h0000);
        reset = 1'b1;
        waitCycles(2);
        readReg(4'd1, 16'h0008);
        readReg(4'd2, 16'h0000);
        readReg(4'd4, 16'h01B1);
        readReg(4'd0, 16'h0000);
        readReg(4'd3, 16'h0000);

        // Test 1: divisor 3, byte 0x55, cycle-accurate waveform.
        applyStimulus(4'd4, 16'h0003);
        bitPeriod = 4;
        txQ.push_back(8'h55);
        applyStimulus(4'd0, 16'h0055);
        @(negedge clk); lat[2] = tx;
        @(negedge clk); lat[1] = tx;
        @(negedge clk); lat[0] = tx;
        checkOutput("tx_latency", {13'd0, lat}, 16'h0006);
        frame    = {1'b1, 8'h55, 1'b0};
        bad      = 0;
        firstBad = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            expLvl = ((k / 4) <= 9) ? frame[k / 4] : 1'b1;
            if (tx !== expLvl) begin
                bad++;
                if (firstBad < 0) firstBad = k;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL tx_waveform: got %0d wrong samples (first at %0d) expected 0",
                     bad, firstBad);
        end
        waitCycles(1);
        readReg(4'd1, 16'h0008);

        // Test 2: FIFO fill while the first byte is in flight, then drops.
        for (int i = 0; i < 5; i++) begin
            txQ.push_back(8'hA1 + 8'(i));
            applyStimulus(4'd0, 16'h00A1 + 16'(i));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'd0, 16'h00B0 + 16'(i));
        end
        readReg(4'd1, 16'h0044);
        applyStimulus(4'd1, 16'h0040);
        readReg(4'd1, 16'h0004);
        waitCycles(260);
        readReg(4'd1, 16'h0008);

        // TX-empty interrupt follows tx_ie.
        applyStimulus(4'd2, 16'h0002);
        waitCycles(2);
        checkOutput("tx_ie_intr", {15'd0, uart_intr}, 16'h0001);
        applyStimulus(4'd2, 16'h0000);
        waitCycles(2);
        checkOutput("tx_ie_intr_off", {15'd0, uart_intr}, 16'h0000);

        // Divisor below the minimum behaves as 3.
        applyStimulus(4'd4, 16'h0001);
        readReg(4'd4, 16'h0001);
        txQ.push_back(8'hC3);
        applyStimulus(4'd0, 16'h00C3);
        waitCycles(50);
        readReg(4'd1, 16'h0008);

        // Test 3: receive 0xA3 at divisor 7; rx_valid rises at mid-stop.
        applyStimulus(4'd4, 16'h0007);
        bitPeriod = 8;
        fork
            sendRxFrame(8'hA3, 1'b1);
            begin
                waitCycles(78);
                readReg(4'd1, 16'h0008);
                readReg(4'd1, 16'h0009);
            end
        join
        readReg(4'd0, 16'h00A3);
        readReg(4'd1, 16'h0008);

        // Test 4: bad stop bit gives frame_err and err interrupt.
        sendRxFrame(8'h5A, 1'b0);
        readReg(4'd1, 16'h0028);
        applyStimulus(4'd2, 16'h0004);
        waitCycles(2);
        checkOutput("err_intr", {15'd0, uart_intr}, 16'h0001);
        applyStimulus(4'd1, 16'h0020);
        waitCycles(2);
        checkOutput("err_intr_clear", {15'd0, uart_intr}, 16'h0000);
        readReg(4'd1, 16'h0008);
        applyStimulus(4'd2, 16'h0000);

        // Test 5: overrun on a full RX FIFO.
        sendRxFrame(8'h11, 1'b1);
        sendRxFrame(8'h22, 1'b1);
        sendRxFrame(8'h33, 1'b1);
        sendRxFrame(8'h44, 1'b1);
        readReg(4'd1, 16'h000B);
        sendRxFrame(8'h55, 1'b1);
        readReg(4'd1, 16'h001B);
        readReg(4'd0, 16'h0011);
        readReg(4'd0, 16'h0022);
        readReg(4'd0, 16'h0033);
        readReg(4'd0, 16'h0044);
        readReg(4'd1, 16'h0018);
        applyStimulus(4'd1, 16'h0010);
        readReg(4'd1, 16'h0008);

        // Same again, but a pop lands on the push cycle: no overrun.
        sendRxFrame(8'h61, 1'b1);
        sendRxFrame(8'h62, 1'b1);
        sendRxFrame(8'h63, 1'b1);
        sendRxFrame(8'h64, 1'b1);
        fork
            sendRxFrame(8'h65, 1'b1);
            begin
                waitCycles(78);
                readReg(4'd0, 16'h0061);
            end
        join
        readReg(4'd1, 16'h000B);
        readReg(4'd0, 16'h0062);
        readReg(4'd0, 16'h0063);
        readReg(4'd0, 16'h0064);
        readReg(4'd0, 16'h0065);
        readReg(4'd1, 16'h0008);

`ifdef UART_LOOPBACK_EN
        // Test 6: internal loopback of 0x3C.
        applyStimulus(4'd4, 16'h0003);
        bitPeriod = 4;
        applyStimulus(4'd2, 16'h0009);
        readReg(4'd2, 16'h0009);
        applyStimulus(4'd0, 16'h003C);
        txHigh = 1'b1;
        for (int i = 0; i < 200; i++) begin
            waitCycles(1);
            if (tx !== 1'b1) txHigh = 1'b0;
            if (uart_intr === 1'b1) break;
        end
        checkOutput("loop_tx_pin", {15'd0, txHigh}, 16'h0001);
        checkOutput("loop_intr", {15'd0, uart_intr}, 16'h0001);
        readReg(4'd0, 16'h003C);
        applyStimulus(4'd2, 16'h0000);
`else
        // Without loopback, control bit 3 is not writable.
        txHigh = 1'b1;
        applyStimulus(4'd2, 16'h000F);
        readReg(4'd2, 16'h0007);
        applyStimulus(4'd2, 16'h0000);
        applyStimulus(4'd4, 16'h0003);
        bitPeriod = 4;
`endif

        // Reset in the middle of a TX frame.
        waitCycles(4);
        monEnable = 1'b0;
        applyStimulus(4'd0, 16'h00F0);
        waitCycles(15);
        reset = 1'b0;
        #1;
        checkOutput("reset_midframe_tx", {15'd0, tx}, 16'h0001);
        checkOutput("reset_midframe_intr", {15'd0, uart_intr}, 16'h0000);
        waitCycles(3);
        reset = 1'b1;
        waitCycles(2);
        readReg(4'd1, 16'h0008);
        readReg(4'd4, 16'h01B1);
        readReg(4'd2, 16'h0000);
        waitCycles(2);

        checkOutput("txq_drained", 16'(txQ.size()), 16'h0000);
        checkOutput("readq_drained", 16'(readQ.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
